// File: rtl/matrix_screen_if.sv
// Display-side bundle for the LED matrix driver: screen index in, scan signals out.
interface matrix_screen_if;
    logic [5:0] screen;
    logic [7:0] row_sel;
    logic [7:0] col;
    logic       frame_start;

    modport master (output screen, input row_sel, col, frame_start);
    modport slave  (input screen, output row_sel, col, frame_start);
endinterface

// File: rtl/matrix_screen_driver.sv
// Row-scanning 8x8 LED matrix driver: renders a once-per-frame latched screen index
// (bar fill, tug-of-war with blinking ends, countdown glyphs) as row_sel/col.
module matrix_screen_driver #(
    parameter int SCAN_DIV     = 4096,
    parameter int BLANK        = 64,
    parameter int BLINK_FRAMES = 32
) (
    input  logic            clk,
    input  logic            reset,
    matrix_screen_if.slave  bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [63:0] GLYPH1 = 64'h0818_2808_0808_3E00;
    localparam logic [63:0] GLYPH2 = 64'h3C42_020C_3040_7E00;
    localparam logic [63:0] GLYPH3 = 64'h3C42_021C_0242_3C00;

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    row_q, row_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          blink_q, blink_d;
    logic [5:0]    screen_q, screen_d;
    logic          started_q, started_d;
    logic [7:0]    row_sel_q, row_sel_d;
    logic [7:0]    col_q, col_d;
    logic          fs_q, fs_d;
    logic          div_end, frame_end;

    function automatic logic [7:0] pixel(input logic [5:0] n, input logic [2:0] row,
                                         input logic blink);
        logic [2:0] r;
        logic [3:0] p;
        logic [2:0] c0, c1;
        logic [7:0] b;
        r = 3'd7 - row;
        b = 8'h00;
        p = 4'd0;
        c0 = 3'd0;
        c1 = 3'd0;
        if (n >= 6'd1 && n <= 6'd15) begin
            // r counts levels from the bottom, so the bar grows upward two steps per row
            if (n >= {2'b00, r, 1'b0} + 6'd1) b = 8'hFF;
            else if (n == {2'b00, r, 1'b0}) b = 8'hF0;
        end else if (n >= 6'd16 && n <= 6'd30) begin
            p  = 4'(n - 6'd16);
            c0 = p[3:1];
            c1 = 3'((p + 4'd1) >> 1);
            b  = (8'h80 >> c0) | (8'h80 >> c1);
            if ((n == 6'd16 || n == 6'd30) && blink) b = 8'h00;
        end else if (n == 6'd31) begin
            b = 8'hFF;
        end else if (n == 6'd32) begin
            b = GLYPH1[{r, 3'b000} +: 8];
        end else if (n == 6'd33) begin
            b = GLYPH2[{r, 3'b000} +: 8];
        end else if (n == 6'd34) begin
            b = GLYPH3[{r, 3'b000} +: 8];
        end
        return b;
    endfunction

    always_comb begin
        div_d     = div_q;
        row_d     = row_q;
        fcnt_d    = fcnt_q;
        blink_d   = blink_q;
        screen_d  = screen_q;
        started_d = started_q;
        div_end   = (div_q == DW'(SCAN_DIV - 1));
        frame_end = div_end && (row_q == 3'd7);

        div_d = div_end ? '0 : div_q + DW'(1);
        if (div_end) row_d = row_q + 3'd1;

        if (frame_end) begin
            screen_d  = bus.screen;
            started_d = 1'b1;
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        // Outputs are registered from next-state so they line up with the counters
        row_sel_d = 8'h01 << row_d;
        col_d     = (div_d < DW'(BLANK)) ? 8'h00 : pixel(screen_d, row_d, blink_d);
        fs_d      = started_d && (row_d == 3'd0) && (div_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            row_q     <= 3'd0;
            fcnt_q    <= '0;
            blink_q   <= 1'b0;
            screen_q  <= 6'd0;
            started_q <= 1'b0;
            row_sel_q <= 8'h01;
            col_q     <= 8'h00;
            fs_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            row_q     <= row_d;
            fcnt_q    <= fcnt_d;
            blink_q   <= blink_d;
            screen_q  <= screen_d;
            started_q <= started_d;
            row_sel_q <= row_sel_d;
            col_q     <= col_d;
            fs_q      <= fs_d;
        end
    end

    assign bus.row_sel     = row_sel_q;
    assign bus.col         = col_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_matrix_screen_driver.sv
// Scoreboard bench for matrix_screen_driver with SCAN_DIV=4, BLANK=1, BLINK_FRAMES=2.
module tb_matrix_screen_driver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    matrix_screen_if bus();

    matrix_screen_driver #(.SCAN_DIV(4), .BLANK(1), .BLINK_FRAMES(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [7:0] rs;
        logic [7:0] col;
        logic       fs;
    } exp_t;

    exp_t        q[$];
    string       tq[$];
    int          vecs = 0;
    int          errs = 0;
    logic        first = 1'b1;
    logic [63:0] cur = 64'h0;

    // Monitor: one expected entry per cycle, sampled on the falling edge
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t  e;
            string t;
            e = q.pop_front();
            t = tq.pop_front();
            vecs++;
            if ({bus.row_sel, bus.col, bus.frame_start} !== e) begin
                errs++;
                $display("FAIL %s: got row_sel=%h col=%h fs=%b, expected row_sel=%h col=%h fs=%b",
                         t, bus.row_sel, bus.col, bus.frame_start, e.rs, e.col, e.fs);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [63:0] b, input int ncyc, input string t);
        exp_t e;
        for (int i = 0; i < ncyc; i++) begin
            int r, d;
            r = i / 4;
            d = i % 4;
            e.rs  = 8'h01 << r;
            e.col = (d == 0) ? 8'h00 : b[8*(7-r) +: 8];
            e.fs  = (i == 0) && !first;
            q.push_back(e);
            tq.push_back(t);
        end
        if (ncyc == 32) first = 1'b0;
    endtask

    task automatic chk(input logic [63:0] b, input int n, input string t);
        repeat (n) begin
            push_frame(b, 32, t);
            cyc(32);
        end
    endtask

    // New screen shows from the next frame; the current frame keeps the old image
    task automatic show(input logic [5:0] s, input logic [63:0] b, input int n, input string t);
        bus.screen = s;
        chk(cur, 1, {t, "_old"});
        chk(b, n, t);
        cur = b;
    endtask

    task automatic do_reset();
        exp_t e;
        e = '{rs: 8'h01, col: 8'h00, fs: 1'b0};
        reset = 1'b1;
        repeat (3) begin
            q.push_back(e);
            tq.push_back("reset");
            cyc(1);
        end
        reset = 1'b0;
        first = 1'b1;
        cur   = 64'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.screen = 6'd15;
        cyc(1);
        // Reset, blank first frame, pulse at clock 32, full bar
        do_reset();
        show(6'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1, "bar15");
        show(6'd2,  64'h0000_0000_0000_F0FF, 1, "bar2");
        show(6'd0,  64'h0, 1, "blank0");
        // Tug-of-war, non-end positions
        show(6'd23, 64'h1818_1818_1818_1818, 1, "tug23");
        show(6'd17, 64'hC0C0_C0C0_C0C0_C0C0, 1, "tug17");
        show(6'd29, 64'h0303_0303_0303_0303, 1, "tug29");
        // Countdown glyphs
        show(6'd34, 64'h3C42_021C_0242_3C00, 1, "glyph3");
        show(6'd33, 64'h3C42_020C_3040_7E00, 1, "glyph2");
        show(6'd32, 64'h0818_2808_0808_3E00, 1, "glyph1");
        show(6'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1, "go31");
        show(6'd40, 64'h0, 1, "blank40");
        // Mid-frame screen change: row 3 of the current frame is still glyph "3"
        show(6'd34, 64'h3C42_021C_0242_3C00, 1, "glyph3b");
        push_frame(cur, 32, "midchg_keep");
        cyc(13);
        bus.screen = 6'd31;
        cyc(19);
        push_frame(64'hFFFF_FFFF_FFFF_FFFF, 32, "midchg_new");
        cyc(5);
        bus.screen = 6'd0;
        cyc(1);
        bus.screen = 6'd31;
        cyc(26);
        chk(64'hFFFF_FFFF_FFFF_FFFF, 1, "glitch_ignored");
        // Mid-frame reset at row 5 div 2, then blink sequence for screen 30
        push_frame(64'hFFFF_FFFF_FFFF_FFFF, 22, "pre_reset");
        cyc(22);
        bus.screen = 6'd30;
        do_reset();
        chk(64'h0, 1, "post_reset_blank");
        chk(64'h0101_0101_0101_0101, 1, "tug30_on1");
        chk(64'h0, 2, "tug30_off");
        chk(64'h0101_0101_0101_0101, 2, "tug30_on2");
        chk(64'h0, 1, "tug30_off2");
        for (int i = 0; i < 100 && q.size() != 0; i++) cyc(1);
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/matrix_screen_driver.md
# matrix_screen_driver

Row-scanning driver for the 8x8 LED matrix. It consumes the 6-bit screen index produced by the single-player and multiplayer game logic and renders it as multiplexed row-select and column-data signals.

- The screen index is sampled once per frame to prevent tearing.
- Bar-fill, tug-of-war and countdown graphics are generated internally.
- The tug-of-war end positions blink.

## Interface
- SCAN_DIV, 4096: clocks per row slot (≥2).
- BLANK, 64: leading clocks of each row slot with columns forced off (1 ≤ BLANK < SCAN_DIV).
- BLINK_FRAMES, 32: frames per blink half-period (≥1).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- screen  in  6  screen index from game logic.
- row_sel  out  8  one-hot row enable, active-high; bit i = row i, row 0 = top.
- col  out  8  column data, active-high; bit 7 = leftmost column (column 0), bit 0 = rightmost.
- frame_start  out  1  one-cycle pulse on first cycle of row 0.

## Operation
- Counters:
  - div counts 0..SCAN_DIV-1.
  - On wrap, row advances 0..7, and 7 wraps to 0.
  - frame counter fcnt counts 0..BLINK_FRAMES-1 on each row 7→0 wrap; on its wrap, blink toggles.
- Screen latch: screen_q captures screen on the last cycle of row 7 (div = SCAN_DIV-1, row = 7). Changes to screen at any other time are ignored until that cycle.
- Pixel byte P(screen_q, row), with r = 7 − row (bottom-up level) and n = screen_q:
  - 0: blank, 0x00.
  - 1–15, bar fill: row byte 0xFF if n ≥ 2r+1; 0xF0 if n = 2r; else 0x00.
  - 16–30, tug-of-war: p = n−16. Column c is lit on all rows if c = p>>1 or c = (p+1)>>1.
    - p=0 → 0x80.
    - p=7 → 0x18.
    - p=14 → 0x01.
  - 16 and 30 only: P = 0x00 while blink = 1.
  - 31, GO: 0xFF on all rows.
  - 32 ("1"), rows 0–7: 08,18,28,08,08,08,3E,00.
  - 33 ("2"), rows 0–7: 3C,42,02,0C,30,40,7E,00.
  - 34 ("3"), rows 0–7: 3C,42,02,1C,02,42,3C,00.
  - 35–63: 0x00.
- Outputs:
  - row_sel = one-hot(row).
  - col = 0x00 when div < BLANK, else P(screen_q, row).
  - frame_start = 1 when row = 0 and div = 0, except in the first frame after reset release.

## Timing
- All outputs are driven directly from flops. In any cycle, row_sel/col/frame_start reflect that cycle's div, row, screen_q and blink state, with no extra pipeline offset.
- Row slot = SCAN_DIV clocks. Frame = 8·SCAN_DIV clocks. Blink half-period = BLINK_FRAMES frames.
- Screen latency: a change in screen is displayed from the next row 0. Worst case is 8·SCAN_DIV clocks after the change.
- Reset values, applied asynchronously and immediately, including mid-frame:
  - div = 0, row = 0, fcnt = 0, blink = 0, screen_q = 0.
  - row_sel = 0x01, col = 0x00, frame_start = 0.
- First frame after reset release renders screen_q = 0 (blank) with no frame_start pulse. The first pulse occurs 8·SCAN_DIV clocks after release.
- The blink toggle and the screen_q update coincide at the 7→0 boundary. The new row 0 uses both new values.
- Exactly one row_sel bit is high in every cycle, including during blanking.

## Test plan
Parameters for all scenarios: SCAN_DIV=4, BLANK=1, BLINK_FRAMES=2.

1. **Reset and first frame.** Hold reset, release with screen=15.
   - During reset: row_sel=0x01, col=0x00.
   - First frame: all col=0x00.
   - frame_start pulses at clock 32.
   - Second frame: col=0xFF on div 1–3 of every row, 0x00 on div 0.
2. **Bar fill.** Screen=2.
   - Row 7 → 0xFF; row 6 → 0xF0; rows 0–5 → 0x00.
   - Screen=0 → all 0x00.
3. **Tug-of-war and blink.** Screens 23, 17, 29, 30.
   - Screen 23 → 0x18 on every row.
   - Screen 17 → 0xC0; screen 29 → 0x03.
   - Screen 30 → 0x01 for 2 frames, 0x00 for 2 frames, repeating.
4. **Countdown glyphs.** Screens 34, 33, 32, 31, 40.
   - Each row matches the glyph table above.
   - Screen 31 → 0xFF on all rows; screen 40 → all 0x00.
5. **Screen change mid-frame.** Change screen 34→31 while row = 3.
   - Rows 3–7 keep glyph "3".
   - Change appears at the next row 0.
   - Pulse on screen during a single mid-frame cycle only → no visible effect.
6. **Mid-frame reset.** Assert reset at row 5, div 2.
   - row_sel=0x01 and col=0x00 immediately.
   - After release: blank first frame, screen_q reloaded on last cycle of row 7.
